// File: rtl/program_counter.sv
// Architectural PC register for the fetch stage.
// Also provides the PC+INCR value and an alignment flag.
module program_counter #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               INCR        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misaligned
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    always_comb begin
        pc_d = pc_in;
        if (reset) begin
            pc_d = RESET_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    // Outputs depend only on pc_q, so feeding them back into pc_in is loop-free.
    assign pc_out     = pc_q;
    assign pc_plus4   = pc_q + WIDTH'(INCR);
    assign misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// Directed vectors plus a per-cycle reference model comparison.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int checks;
    int errors;

    longint model_pc;
    bit     model_valid;

    program_counter #(
        .WIDTH      (32),
        .RESET_VALUE(32'h0000_0000),
        .INCR       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .pc_out    (pc_out),
        .pc_plus4  (pc_plus4),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a register that takes 0 on reset, else whatever pc_in is.
    always @(posedge clk) begin
        if (reset === 1'b1) model_pc <= 0;
        else model_pc <= longint'(pc_in);
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            longint exp_p4;
            bit     exp_mis;
            exp_p4  = (model_pc + 4) % 64'h1_0000_0000;
            exp_mis = (model_pc % 4) != 0;
            checks++;
            if (longint'(pc_out) != model_pc) begin
                errors++;
                $display("FAIL model_pc_out actual=%h required=%h",
                         pc_out, model_pc[31:0]);
            end
            checks++;
            if (longint'(pc_plus4) != exp_p4) begin
                errors++;
                $display("FAIL model_pc_plus4 actual=%h required=%h",
                         pc_plus4, exp_p4[31:0]);
            end
            checks++;
            if (misaligned !== exp_mis) begin
                errors++;
                $display("FAIL model_misaligned actual=%b required=%b",
                         misaligned, exp_mis);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_valid = 1'b0;
        model_pc    = 0;
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        pc_in       = 32'h0;

        step();
        chk("reset_pc_out", pc_out, 32'h0);
        chk("reset_pc_plus4", pc_plus4, 32'h4);
        chk("reset_misaligned", {31'b0, misaligned}, 32'h0);

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_in = pc_out + 32'd4;
            step();
            step();
        end
        chk("seq_incr", pc_out, 32'hC);

        pc_in = 32'h80;
        step();
        chk("jump_load", pc_out, 32'h80);
        pc_in = pc_out + 32'd4;
        step();
        chk("jump_incr", pc_out, 32'h84);

        reset = 1'b1;
        pc_in = 32'h200;
        step();
        chk("reset_priority", pc_out, 32'h0);
        reset = 1'b0;
        step();
        chk("reset_release", pc_out, 32'h200);

        pc_in = 32'hFFFF_FFFC;
        step();
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);

        pc_in = 32'h0000_0082;
        step();
        chk("misalign_pc_out", pc_out, 32'h82);
        chk("misalign_flag", {31'b0, misaligned}, 32'h1);
        chk("misalign_plus4", pc_plus4, 32'h86);

        pc_in = 32'h40;
        step();
        for (int i = 0; i < 5; i++) begin
            pc_in = pc_out;
            step();
            chk("hold", pc_out, 32'h40);
        end

        // A reset pulse between edges must not reach the register.
        pc_in = 32'h40;
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
        chk("reset_between_edges", pc_out, 32'h40);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
